hazard_scoreboard: RTL and testbench

- Parametrised successor to the ID-stage load/MFC0 stall detector: a per-register countdown scoreboard replaces the fixed EXE/MEM1/MEM2 destination compares.
- Supports ISSUE_WIDTH decode slots and a programmable result latency per instruction (load, MFC0, multicycle ops).
- Sits in ID, drives the ID stall and a per-slot issue mask to the ID/EX register, and exports a stall-cycle performance counter.

---
 rtl/hazard_scoreboard_pkg.sv | 21 ++
 rtl/scoreboard_entry.sv | 41 ++++
 rtl/hazard_scoreboard.sv | 136 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared decode-stage definitions for the hazard scoreboard: result latencies
// and the per-slot view of a decoded instruction.
package hazard_scoreboard_pkg;

    localparam int LAT_LOAD = 3;
    localparam int LAT_MFC0 = 2;
    localparam int LAT_ALU  = 0;

    localparam int REG_W    = 5;
    localparam int SB_LAT_W = $clog2(LAT_LOAD + 1);

    typedef struct packed {
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [1:0]          rsrtRead;
        logic [REG_W-1:0]    Dst;
        logic                WbEn;
        logic [SB_LAT_W-1:0] Lat;
    } IssueSlot_t;

endpackage

// File: rtl/scoreboard_entry.sv
// One register's countdown: cycles left before its pending result can be
// forwarded. Clear beats freeze, freeze beats load, load beats decrement.
module scoreboard_entry #(
    parameter int LAT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             freeze,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic [LAT_W-1:0] cnt
);

    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (freeze) begin
            cnt_d = cnt_q;
        end else if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage data-hazard detector: per-register countdown scoreboard, in-order
// issue mask for the decode slots, and a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int ISSUE_WIDTH = 2,
    parameter int MAX_LAT     = LAT_LOAD,
    parameter int LAT_W       = $clog2(MAX_LAT + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ISSUE_WIDTH-1:0]              ID_Valid,
    input  logic [ISSUE_WIDTH-1:0][REG_W-1:0]   ID_rs,
    input  logic [ISSUE_WIDTH-1:0][REG_W-1:0]   ID_rt,
    input  logic [ISSUE_WIDTH-1:0][1:0]         ID_rsrtRead,
    input  logic [ISSUE_WIDTH-1:0][REG_W-1:0]   ID_Dst,
    input  logic [ISSUE_WIDTH-1:0]              ID_WbEn,
    input  logic [ISSUE_WIDTH-1:0][LAT_W-1:0]   ID_Lat,
    input  logic                                Pipe_Freeze,
    input  logic                                Flush,
    output logic                                ID_DH_Stall,
    output logic [ISSUE_WIDTH-1:0]              ID_Issue,
    output logic [LAT_W-1:0]                    ID_Stall_Wait,
    output logic [31:0]                         DH_Stall_Cnt
);

    IssueSlot_t [ISSUE_WIDTH-1:0] slot;
    logic [LAT_W-1:0]             cnt [NUM_REGS];
    logic [ISSUE_WIDTH-1:0]       blocked;
    logic [ISSUE_WIDTH-1:0]       pair_raw;
    logic [ISSUE_WIDTH-1:0]       issue;
    logic                         stall;
    logic [LAT_W-1:0]             wait_max;
    logic [31:0]                  stall_cnt_q;
    logic [31:0]                  stall_cnt_d;

    always_comb begin
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            slot[k].rs       = ID_rs[k];
            slot[k].rt       = ID_rt[k];
            slot[k].rsrtRead = ID_rsrtRead[k];
            slot[k].Dst      = ID_Dst[k];
            slot[k].WbEn     = ID_WbEn[k];
            slot[k].Lat      = SB_LAT_W'(ID_Lat[k]);
        end
    end

    // Younger slots also check older same-bundle writers: there is no
    // same-cycle bypass between decode slots.
    always_comb begin
        blocked  = '0;
        pair_raw = '0;
        issue    = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            blocked[k] = (slot[k].rsrtRead[1] && (cnt[slot[k].rs] != '0)) ||
                         (slot[k].rsrtRead[0] && (cnt[slot[k].rt] != '0));
            for (int j = 0; j < k; j++) begin
                if (slot[j].WbEn && (slot[j].Dst != '0) &&
                    ((slot[k].rsrtRead[1] && (slot[k].rs == slot[j].Dst)) ||
                     (slot[k].rsrtRead[0] && (slot[k].rt == slot[j].Dst)))) begin
                    pair_raw[k] = 1'b1;
                end
            end
        end
        issue[0] = ID_Valid[0] & ~blocked[0] & ~Pipe_Freeze & ~Flush;
        for (int k = 1; k < ISSUE_WIDTH; k++) begin
            issue[k] = issue[k-1] & ID_Valid[k] & ~blocked[k] & ~pair_raw[k];
        end
    end

    always_comb begin
        stall    = ID_Valid[0] & blocked[0];
        wait_max = '0;
        if (stall) begin
            if (slot[0].rsrtRead[1] && (cnt[slot[0].rs] > wait_max)) begin
                wait_max = cnt[slot[0].rs];
            end
            if (slot[0].rsrtRead[0] && (cnt[slot[0].rt] > wait_max)) begin
                wait_max = cnt[slot[0].rt];
            end
        end
    end

    assign cnt[0] = '0;

    // Later slots are scanned last, so the youngest writer's latency wins.
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        logic             ld;
        logic [LAT_W-1:0] ld_val;

        always_comb begin
            ld     = 1'b0;
            ld_val = '0;
            for (int k = 0; k < ISSUE_WIDTH; k++) begin
                if (issue[k] && slot[k].WbEn && (slot[k].Dst == REG_W'(r))) begin
                    ld     = 1'b1;
                    ld_val = LAT_W'(slot[k].Lat);
                end
            end
        end

        scoreboard_entry #(
            .LAT_W   (LAT_W)
        ) u_entry (
            .clk     (clk),
            .rst     (rst),
            .clear   (Flush),
            .freeze  (Pipe_Freeze),
            .load    (ld),
            .load_val(ld_val),
            .cnt     (cnt[r])
        );
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !Pipe_Freeze && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ID_DH_Stall   = stall;
    assign ID_Issue      = issue;
    assign ID_Stall_Wait = wait_max;
    assign DH_Stall_Cnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, MFC0, pair RAW, freeze,
// flush, same-destination pairs and asynchronous reset.
module tb_hazard_scoreboard;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      ID_Valid;
    logic [1:0][4:0] ID_rs;
    logic [1:0][4:0] ID_rt;
    logic [1:0][1:0] ID_rsrtRead;
    logic [1:0][4:0] ID_Dst;
    logic [1:0]      ID_WbEn;
    logic [1:0][1:0] ID_Lat;
    logic            Pipe_Freeze;
    logic            Flush;
    logic            ID_DH_Stall;
    logic [1:0]      ID_Issue;
    logic [1:0]      ID_Stall_Wait;
    logic [31:0]     DH_Stall_Cnt;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .ID_Valid     (ID_Valid),
        .ID_rs        (ID_rs),
        .ID_rt        (ID_rt),
        .ID_rsrtRead  (ID_rsrtRead),
        .ID_Dst       (ID_Dst),
        .ID_WbEn      (ID_WbEn),
        .ID_Lat       (ID_Lat),
        .Pipe_Freeze  (Pipe_Freeze),
        .Flush        (Flush),
        .ID_DH_Stall  (ID_DH_Stall),
        .ID_Issue     (ID_Issue),
        .ID_Stall_Wait(ID_Stall_Wait),
        .DH_Stall_Cnt (DH_Stall_Cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ID_Valid    = '0;
        ID_rs       = '0;
        ID_rt       = '0;
        ID_rsrtRead = '0;
        ID_Dst      = '0;
        ID_WbEn     = '0;
        ID_Lat      = '0;
        Pipe_Freeze = 1'b0;
        Flush       = 1'b0;
    endtask

    task automatic set_slot(input int k, input logic v, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [1:0] rd,
                            input logic [4:0] dst, input logic wb, input logic [1:0] lat);
        ID_Valid[k]    = v;
        ID_rs[k]       = rs;
        ID_rt[k]       = rt;
        ID_rsrtRead[k] = rd;
        ID_Dst[k]      = dst;
        ID_WbEn[k]     = wb;
        ID_Lat[k]      = lat;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        ID_Valid = 2'b11;
        #2;
        vectors++; if (ID_Issue !== 2'b11) begin miscompares++; $display("FAIL reset_issue: got %b want %b", ID_Issue, 2'b11); end
        vectors++; if (ID_DH_Stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", ID_DH_Stall); end
        vectors++; if (ID_Stall_Wait !== 2'd0) begin miscompares++; $display("FAIL reset_wait: got %0d want 0", ID_Stall_Wait); end
        vectors++; if (DH_Stall_Cnt !== 32'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", DH_Stall_Cnt); end
        tick();
        tick();
        rst = 1'b0;
        idle();
    endtask

    task automatic test_load_use();
        idle();
        set_slot(0, 1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 2'd3);
        #1;
        vectors++; if (ID_Issue !== 2'b01) begin miscompares++; $display("FAIL load_issue: got %b want 01", ID_Issue); end
        tick();
        idle();
        set_slot(0, 1'b1, 5'd5, 5'd0, 2'b10, 5'd6, 1'b1, 2'd0);
        for (int w = 3; w >= 1; w--) begin
            #1;
            vectors++; if (ID_DH_Stall !== 1'b1) begin miscompares++; $display("FAIL load_stall: got %b want 1 (wait %0d)", ID_DH_Stall, w); end
            vectors++; if (ID_Stall_Wait !== 2'(w)) begin miscompares++; $display("FAIL load_wait: got %0d want %0d", ID_Stall_Wait, w); end
            vectors++; if (ID_Issue !== 2'b00) begin miscompares++; $display("FAIL load_block: got %b want 00", ID_Issue); end
            tick();
        end
        #1;
        vectors++; if (ID_Issue !== 2'b01) begin miscompares++; $display("FAIL load_release: got %b want 01", ID_Issue); end
        vectors++; if (ID_DH_Stall !== 1'b0) begin miscompares++; $display("FAIL load_nostall: got %b want 0", ID_DH_Stall); end
        vectors++; if (DH_Stall_Cnt !== 32'd3) begin miscompares++; $display("FAIL load_cnt: got %0d want 3", DH_Stall_Cnt); end
        tick();
        idle();
    endtask

    task automatic test_mfc0();
        idle();
        set_slot(0, 1'b1, 5'd0, 5'd0, 2'b00, 5'd8, 1'b1, 2'd2);
        tick();
        idle();
        set_slot(0, 1'b1, 5'd0, 5'd8, 2'b01, 5'd9, 1'b0, 2'd0);
        for (int w = 2; w >= 1; w--) begin
            #1;
            vectors++; if (ID_DH_Stall !== 1'b1) begin miscompares++; $display("FAIL mfc0_stall: got %b want 1", ID_DH_Stall); end
            vectors++; if (ID_Stall_Wait !== 2'(w)) begin miscompares++; $display("FAIL mfc0_wait: got %0d want %0d", ID_Stall_Wait, w); end
            tick();
        end
        #1;
        vectors++; if (ID_Issue !== 2'b01) begin miscompares++; $display("FAIL mfc0_release: got %b want 01", ID_Issue); end
        vectors++; if (DH_Stall_Cnt !== 32'd5) begin miscompares++; $display("FAIL mfc0_cnt: got %0d want 5", DH_Stall_Cnt); end
        tick();
        idle();
        set_slot(0, 1'b1, 5'd0, 5'd0, 2'b00, 5'd8, 1'b1, 2'd2);
        tick();
        idle();
        set_slot(0, 1'b1, 5'd0, 5'd8, 2'b10, 5'd0, 1'b0, 2'd0);
        #1;
        vectors++; if (ID_DH_Stall !== 1'b0) begin miscompares++; $display("FAIL mfc0_rs0_stall: got %b want 0", ID_DH_Stall); end
        vectors++; if (ID_Issue !== 2'b01) begin miscompares++; $display("FAIL mfc0_rs0_issue: got %b want 01", ID_Issue); end
        tick();
        idle();
        tick();
        tick();
    endtask

    task automatic test_pair_raw();
        idle();
        set_slot(0, 1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 2'd0);
        set_slot(1, 1'b1, 5'd3, 5'd0, 2'b10, 5'd4, 1'b1, 2'd0);
        #1;
        vectors++; if (ID_Issue !== 2'b01) begin miscompares++; $display("FAIL pair_rs_issue: got %b want 01", ID_Issue); end
        vectors++; if (ID_DH_Stall !== 1'b0) begin miscompares++; $display("FAIL pair_rs_stall: got %b want 0", ID_DH_Stall); end
        tick();
        idle();
        set_slot(0, 1'b1, 5'd3, 5'd0, 2'b10, 5'd4, 1'b1, 2'd0);
        #1;
        vectors++; if (ID_Issue !== 2'b01) begin miscompares++; $display("FAIL pair_follow: got %b want 01", ID_Issue); end
        tick();
        idle();
        set_slot(0, 1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 2'd0);
        set_slot(1, 1'b1, 5'd0, 5'd3, 2'b01, 5'd4, 1'b1, 2'd0);
        #1;
        vectors++; if (ID_Issue !== 2'b01) begin miscompares++; $display("FAIL pair_rt_issue: got %b want 01", ID_Issue); end
        ID_rt[1] = 5'd4;
        #1;
        vectors++; if (ID_Issue !== 2'b11) begin miscompares++; $display("FAIL pair_indep: got %b want 11", ID_Issue); end
        ID_rt[1]   = 5'd3;
        ID_WbEn[0] = 1'b0;
        #1;
        vectors++; if (ID_Issue !== 2'b11) begin miscompares++; $display("FAIL pair_nowb: got %b want 11", ID_Issue); end
        tick();
        idle();
    endtask

    task automatic test_freeze();
        idle();
        set_slot(0, 1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 2'd3);
        tick();
        idle();
        set_slot(0, 1'b1, 5'd9, 5'd0, 2'b10, 5'd10, 1'b1, 2'd0);
        Pipe_Freeze = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++; if (ID_DH_Stall !== 1'b1) begin miscompares++; $display("FAIL frz_stall: got %b want 1", ID_DH_Stall); end
            vectors++; if (ID_Stall_Wait !== 2'd3) begin miscompares++; $display("FAIL frz_wait: got %0d want 3", ID_Stall_Wait); end
            vectors++; if (DH_Stall_Cnt !== 32'd5) begin miscompares++; $display("FAIL frz_cnt: got %0d want 5", DH_Stall_Cnt); end
            tick();
        end
        Pipe_Freeze = 1'b0;
        for (int w = 3; w >= 1; w--) begin
            #1;
            vectors++; if (ID_Stall_Wait !== 2'(w)) begin miscompares++; $display("FAIL frz_post_wait: got %0d want %0d", ID_Stall_Wait, w); end
            tick();
        end
        #1;
        vectors++; if (ID_Issue !== 2'b01) begin miscompares++; $display("FAIL frz_release: got %b want 01", ID_Issue); end
        vectors++; if (DH_Stall_Cnt !== 32'd8) begin miscompares++; $display("FAIL frz_post_cnt: got %0d want 8", DH_Stall_Cnt); end
        tick();
        idle();
    endtask

    task automatic test_flush();
        idle();
        set_slot(0, 1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 2'd3);
        tick();
        idle();
        set_slot(0, 1'b1, 5'd9, 5'd0, 2'b10, 5'd10, 1'b1, 2'd0);
        Flush = 1'b1;
        #1;
        vectors++; if (ID_DH_Stall !== 1'b1) begin miscompares++; $display("FAIL flush_stall: got %b want 1", ID_DH_Stall); end
        vectors++; if (ID_Issue !== 2'b00) begin miscompares++; $display("FAIL flush_block: got %b want 00", ID_Issue); end
        tick();
        Flush = 1'b0;
        #1;
        vectors++; if (ID_Issue !== 2'b01) begin miscompares++; $display("FAIL flush_clear: got %b want 01", ID_Issue); end
        vectors++; if (DH_Stall_Cnt !== 32'd9) begin miscompares++; $display("FAIL flush_cnt: got %0d want 9", DH_Stall_Cnt); end
        tick();
        idle();
        set_slot(0, 1'b1, 5'd0, 5'd0, 2'b00, 5'd10, 1'b1, 2'd3);
        Flush = 1'b1;
        #1;
        vectors++; if (ID_Issue !== 2'b00) begin miscompares++; $display("FAIL flush_issue: got %b want 00", ID_Issue); end
        tick();
        idle();
        set_slot(0, 1'b1, 5'd10, 5'd0, 2'b10, 5'd0, 1'b0, 2'd0);
        #1;
        vectors++; if (ID_DH_Stall !== 1'b0) begin miscompares++; $display("FAIL flush_norecord: got %b want 0", ID_DH_Stall); end
        tick();
        idle();
    endtask

    task automatic test_same_dst_and_reset();
        idle();
        set_slot(0, 1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 2'd3);
        set_slot(1, 1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 2'd0);
        #1;
        vectors++; if (ID_Issue !== 2'b11) begin miscompares++; $display("FAIL same_issue: got %b want 11", ID_Issue); end
        tick();
        idle();
        set_slot(0, 1'b1, 5'd7, 5'd0, 2'b10, 5'd0, 1'b0, 2'd0);
        #1;
        vectors++; if (ID_DH_Stall !== 1'b0) begin miscompares++; $display("FAIL same_slot1_wins: got %b want 0", ID_DH_Stall); end
        tick();
        idle();
        set_slot(0, 1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 2'd0);
        set_slot(1, 1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 2'd3);
        tick();
        idle();
        set_slot(0, 1'b1, 5'd7, 5'd0, 2'b10, 5'd0, 1'b0, 2'd0);
        #1;
        vectors++; if (ID_Stall_Wait !== 2'd3) begin miscompares++; $display("FAIL same_rev_wait: got %0d want 3", ID_Stall_Wait); end
        tick();
        #3;
        rst = 1'b1;
        #1;
        vectors++; if (ID_DH_Stall !== 1'b0) begin miscompares++; $display("FAIL arst_stall: got %b want 0", ID_DH_Stall); end
        vectors++; if (ID_Issue !== 2'b01) begin miscompares++; $display("FAIL arst_issue: got %b want 01", ID_Issue); end
        vectors++; if (DH_Stall_Cnt !== 32'd0) begin miscompares++; $display("FAIL arst_cnt: got %0d want 0", DH_Stall_Cnt); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++; if (ID_Stall_Wait !== 2'd0) begin miscompares++; $display("FAIL arst_wait: got %0d want 0", ID_Stall_Wait); end
        tick();
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mfc0();
        test_pair_raw();
        test_freeze();
        test_flush();
        test_same_dst_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
